// File: rtl/keccak_theta_pipe.sv
// Keccak-f theta step as a two-stage elastic pipeline (pushin/stop handshake).
// Stage 1 captures the state and its column parities; stage 2 applies theta.
module keccak_theta_pipe #(
    parameter int LANE_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pushin,
    output logic                  stopout,
    input  logic [25*LANE_W-1:0]  state_in,
    input  logic                  bypass_in,
    input  logic [TAG_W-1:0]      tag_in,
    output logic                  pushout,
    input  logic                  stopin,
    output logic [25*LANE_W-1:0]  state_out,
    output logic [TAG_W-1:0]      tag_out,
    output logic [1:0]            inflight
);
    localparam int SW = 25 * LANE_W;
    localparam int CW = 5 * LANE_W;

    if (!(LANE_W == 1 || LANE_W == 2 || LANE_W == 4 || LANE_W == 8 ||
          LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
        $error("keccak_theta_pipe: LANE_W must be a power of two from 1 to 64");
    end

    // Handshake: a transfer happens on a rising edge when pushin & !stopout
    // (upstream) or pushout & !stopin (downstream); offered data holds until then.
    logic              s1_v_q, s1_v_d;
    logic [SW-1:0]     s1_a_q, s1_a_d;
    logic [CW-1:0]     s1_c_q, s1_c_d;
    logic              s1_byp_q, s1_byp_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic              s2_v_q, s2_v_d;
    logic [SW-1:0]     s2_a_q, s2_a_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
    logic [1:0]        inflight_q, inflight_d;

    logic              s2_load;
    logic              accept;
    logic [CW-1:0]     c_in;
    logic [SW-1:0]     theta_res;
    logic [LANE_W-1:0] d_lane;

    // Rotate left by one; written bitwise so LANE_W=1 degenerates to identity.
    function automatic logic [LANE_W-1:0] rotl1(input logic [LANE_W-1:0] v);
        logic [LANE_W-1:0] r;
        for (int i = 0; i < LANE_W; i++) begin
            r[i] = v[(i + LANE_W - 1) % LANE_W];
        end
        return r;
    endfunction

    always_comb begin
        c_in = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                c_in[x*LANE_W +: LANE_W] = c_in[x*LANE_W +: LANE_W]
                                         ^ state_in[(x + 5*y)*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        theta_res = '0;
        d_lane    = '0;
        for (int x = 0; x < 5; x++) begin
            d_lane = s1_c_q[((x + 4) % 5)*LANE_W +: LANE_W]
                   ^ rotl1(s1_c_q[((x + 1) % 5)*LANE_W +: LANE_W]);
            for (int y = 0; y < 5; y++) begin
                theta_res[(x + 5*y)*LANE_W +: LANE_W] =
                    s1_a_q[(x + 5*y)*LANE_W +: LANE_W] ^ d_lane;
            end
        end
    end

    always_comb begin
        s2_load = s1_v_q & (~s2_v_q | ~stopin);
        stopout = s1_v_q & ~s2_load;
        accept  = pushin & ~stopout;

        s1_v_d   = s1_v_q;
        s1_a_d   = s1_a_q;
        s1_c_d   = s1_c_q;
        s1_byp_d = s1_byp_q;
        s1_tag_d = s1_tag_q;
        s2_v_d   = s2_v_q;
        s2_a_d   = s2_a_q;
        s2_tag_d = s2_tag_q;

        // S1 may refill in the same cycle S2 drains it.
        if (accept) begin
            s1_v_d   = 1'b1;
            s1_a_d   = state_in;
            s1_c_d   = c_in;
            s1_byp_d = bypass_in;
            s1_tag_d = tag_in;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end

        if (s2_load) begin
            s2_v_d   = 1'b1;
            s2_a_d   = s1_byp_q ? s1_a_q : theta_res;
            s2_tag_d = s1_tag_q;
        end else if (s2_v_q & ~stopin) begin
            s2_v_d = 1'b0;
        end

        inflight_d = {1'b0, s1_v_d} + {1'b0, s2_v_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_c_q     <= '0;
            s1_byp_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_a_q     <= '0;
            s2_tag_q   <= '0;
            inflight_q <= 2'd0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_a_q     <= s1_a_d;
            s1_c_q     <= s1_c_d;
            s1_byp_q   <= s1_byp_d;
            s1_tag_q   <= s1_tag_d;
            s2_v_q     <= s2_v_d;
            s2_a_q     <= s2_a_d;
            s2_tag_q   <= s2_tag_d;
            inflight_q <= inflight_d;
        end
    end

    assign pushout   = s2_v_q;
    assign state_out = s2_a_q;
    assign tag_out   = s2_tag_q;
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_keccak_theta_pipe.sv
// Directed bench for keccak_theta_pipe: a LANE_W=64 instance for most steps
// and a LANE_W=8 instance for the rotate wrap-around case.
module tb_keccak_theta_pipe;
    logic          clk = 1'b0;
    logic          reset;
    logic          pushin, stopin, bypass_in, stopout, pushout;
    logic [1599:0] state_in, state_out;
    logic [3:0]    tag_in, tag_out;
    logic [1:0]    inflight;

    logic          pushin8, stopin8, bypass8, stopout8, pushout8;
    logic [199:0]  state_in8, state_out8;
    logic [3:0]    tag_in8, tag_out8;
    logic [1:0]    inflight8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    keccak_theta_pipe #(.LANE_W(64), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .pushin(pushin), .stopout(stopout),
        .state_in(state_in), .bypass_in(bypass_in), .tag_in(tag_in),
        .pushout(pushout), .stopin(stopin), .state_out(state_out),
        .tag_out(tag_out), .inflight(inflight)
    );

    keccak_theta_pipe #(.LANE_W(8), .TAG_W(4)) dut8 (
        .clk(clk), .reset(reset), .pushin(pushin8), .stopout(stopout8),
        .state_in(state_in8), .bypass_in(bypass8), .tag_in(tag_in8),
        .pushout(pushout8), .stopin(stopin8), .state_out(state_out8),
        .tag_out(tag_out8), .inflight(inflight8)
    );

    function automatic logic [1599:0] lane64(input int x, input int y, input logic [63:0] v);
        logic [1599:0] r;
        r = '0;
        r[(x + 5*y)*64 +: 64] = v;
        return r;
    endfunction

    function automatic logic [199:0] lane8(input int x, input int y, input logic [7:0] v);
        logic [199:0] r;
        r = '0;
        r[(x + 5*y)*8 +: 8] = v;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1599:0] obs, input logic [1599:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Push one state into an idle pipe and check it emerges two edges later.
    task automatic send64(input string name, input logic [1599:0] st, input logic byp,
                          input logic [3:0] tg, input logic [1599:0] exp);
        pushin    = 1'b1;
        state_in  = st;
        bypass_in = byp;
        tag_in    = tg;
        step();
        pushin   = 1'b0;
        state_in = '0;
        chk({name, "_pushout_n1"}, 1600'(pushout), 1600'(1'b0));
        step();
        chk({name, "_pushout_n2"}, 1600'(pushout), 1600'(1'b1));
        chk({name, "_state"}, state_out, exp);
        chk({name, "_tag"}, 1600'(tag_out), 1600'(tg));
        step();
        chk({name, "_drained"}, 1600'(inflight), 1600'(2'd0));
    endtask

    logic [1599:0] exp_s, rnd_s;

    initial begin
        reset = 1'b1;
        pushin = 1'b0; stopin = 1'b0; bypass_in = 1'b0; state_in = '0; tag_in = '0;
        pushin8 = 1'b0; stopin8 = 1'b0; bypass8 = 1'b0; state_in8 = '0; tag_in8 = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_pushout", 1600'(pushout), 1600'(1'b0));
        chk("rst_stopout", 1600'(stopout), 1600'(1'b0));
        chk("rst_inflight", 1600'(inflight), 1600'(2'd0));
        chk("rst_state", state_out, '0);
        chk("rst_tag", 1600'(tag_out), 1600'(4'd0));

        // T1 zeros
        send64("t1", '0, 1'b0, 4'd5, '0);

        // T2 single bit in lane(0,0)
        exp_s = lane64(0, 0, 64'h1);
        for (int y = 0; y < 5; y++) begin
            exp_s |= lane64(1, y, 64'h1) | lane64(4, y, 64'h2);
        end
        send64("t2", lane64(0, 0, 64'h1), 1'b0, 4'd6, exp_s);

        // T3 wrap at LANE_W=8
        pushin8   = 1'b1;
        state_in8 = lane8(2, 0, 8'h80);
        tag_in8   = 4'd3;
        step();
        pushin8 = 1'b0;
        step();
        chk("t3_pushout", 1600'(pushout8), 1600'(1'b1));
        begin
            logic [199:0] e8;
            e8 = lane8(2, 0, 8'h80);
            for (int y = 0; y < 5; y++) begin
                e8 |= lane8(3, y, 8'h80) | lane8(1, y, 8'h01);
            end
            chk("t3_state", 1600'(state_out8), 1600'(e8));
        end
        chk("t3_tag", 1600'(tag_out8), 1600'(4'd3));
        step();

        // T4 backpressure
        stopin = 1'b1;
        pushin = 1'b1;
        tag_in = 4'd1;
        step();
        tag_in = 4'd2;
        chk("t4_stopout_1", 1600'(stopout), 1600'(1'b0));
        step();
        tag_in = 4'd3;
        chk("t4_stopout_2", 1600'(stopout), 1600'(1'b1));
        chk("t4_inflight_peak", 1600'(inflight), 1600'(2'd2));
        step();
        chk("t4_stopout_held", 1600'(stopout), 1600'(1'b1));
        chk("t4_hold_pushout", 1600'(pushout), 1600'(1'b1));
        chk("t4_hold_tag", 1600'(tag_out), 1600'(4'd1));
        stopin = 1'b0;
        #1;
        chk("t4_stopout_release", 1600'(stopout), 1600'(1'b0));
        step();
        pushin = 1'b0;
        chk("t4_out_tag2", 1600'(tag_out), 1600'(4'd2));
        chk("t4_out_v2", 1600'(pushout), 1600'(1'b1));
        chk("t4_inflight_refill", 1600'(inflight), 1600'(2'd2));
        step();
        chk("t4_out_tag3", 1600'(tag_out), 1600'(4'd3));
        chk("t4_out_v3", 1600'(pushout), 1600'(1'b1));
        chk("t4_inflight_1", 1600'(inflight), 1600'(2'd1));
        step();
        chk("t4_empty_pushout", 1600'(pushout), 1600'(1'b0));
        chk("t4_empty_inflight", 1600'(inflight), 1600'(2'd0));

        // T5 bypass, then a theta transfer: lane(1,2) bit 63
        for (int i = 0; i < 50; i++) begin
            rnd_s[i*32 +: 32] = $urandom();
        end
        send64("t5_bypass", rnd_s, 1'b1, 4'd7, rnd_s);
        exp_s = lane64(1, 2, 64'h8000_0000_0000_0000);
        for (int y = 0; y < 5; y++) begin
            exp_s |= lane64(2, y, 64'h8000_0000_0000_0000) | lane64(0, y, 64'h1);
        end
        send64("t5_theta", lane64(1, 2, 64'h8000_0000_0000_0000), 1'b0, 4'd4, exp_s);

        // T6 reset with two states in flight
        pushin   = 1'b1;
        state_in = rnd_s;
        tag_in   = 4'd8;
        step();
        tag_in = 4'd9;
        step();
        chk("t6_full", 1600'(inflight), 1600'(2'd2));
        reset = 1'b1;
        step();
        reset  = 1'b0;
        pushin = 1'b0;
        chk("t6_pushout", 1600'(pushout), 1600'(1'b0));
        chk("t6_inflight", 1600'(inflight), 1600'(2'd0));
        chk("t6_state", state_out, '0);
        chk("t6_stopout", 1600'(stopout), 1600'(1'b0));
        exp_s = lane64(0, 0, 64'h1);
        for (int y = 0; y < 5; y++) begin
            exp_s |= lane64(1, y, 64'h1) | lane64(4, y, 64'h2);
        end
        send64("t6_fresh", lane64(0, 0, 64'h1), 1'b0, 4'hA, exp_s);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
